// File: rtl/mem_stream_pkg.sv
// mem_stream_pkg: shared state encoding and address-width helper for the stream reader
package mem_stream_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_t;

    localparam int MIN_ADDR_W = 1;

    // A one-word memory still needs a one-bit address port
    function automatic int addr_w(input int height);
        return (height > 1) ? $clog2(height) : MIN_ADDR_W;
    endfunction

endpackage

// File: rtl/mem_stream_reader_fifo.sv
// stream_fifo: synchronous FIFO with registered storage and wrap-bit pointers
module stream_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    // Flags, head word and pointer advance; a push into a full FIFO is allowed only alongside a pop
    always_comb begin
        empty_o = wr_q == rd_q;
        full_o  = (wr_q[PW-1:0] == rd_q[PW-1:0]) && (wr_q[PW] != rd_q[PW]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = wr_q + (PW+1)'(do_push);
        rd_d    = rd_q + (PW+1)'(do_pop);
        dout_o  = mem_q[rd_q[PW-1:0]];
    end

    // Pointer registers, cleared by reset so the FIFO comes up empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: walks COUNT addresses from BASE, reads only when the output FIFO can take the word
// Optional MEM_STREAM_PERF_EN adds the stall_cycles_o backpressure counter.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int HEIGHT     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int ADDR_W     = addr_w(HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] read_addr_o,
    output logic              read_en_o,
    input  logic [WIDTH-1:0]  qout_i,
    output logic [WIDTH-1:0]  out_data_o,
    output logic              out_last_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
`ifdef MEM_STREAM_PERF_EN
    ,
    output logic [31:0]       stall_cycles_o
`endif
);
    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              done_q;
    logic              accept, pop, full, empty, is_last;
    logic [WIDTH:0]    head;

    stream_fifo #(.WIDTH(WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (read_en_o),
        .din_i  ({qout_i, is_last}),
        .pop_i  (pop),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: empty bursts skip straight to DRAIN, the last issued read ends ISSUE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (count_i != '0) ? ISSUE : DRAIN;
            ISSUE:   if (read_en_o && is_last) state_d = DRAIN;
            DRAIN:   if (empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: a pop frees a slot in the same cycle, so a full FIFO being drained still reads
    always_comb begin
        accept      = (state_q == IDLE) && start_i;
        pop         = !empty && out_ready_i;
        is_last     = rem_q == CNT_W'(1);
        busy_o      = state_q != IDLE;
        read_en_o   = (state_q == ISSUE) && (!full || pop);
        done_o      = done_q;
        read_addr_o = addr_q;
        out_valid_o = !empty;
        out_last_o  = !empty && head[0];
        out_data_o  = head[WIDTH:1];
        addr_d      = accept ? base_addr_i : read_en_o ? addr_q + ADDR_W'(1) : addr_q;
        rem_d       = accept ? count_i : read_en_o ? rem_q - CNT_W'(1) : rem_q;
    end

    // Address/remaining counters and the registered done pulse on DRAIN exit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            done_q <= (state_q == DRAIN) && empty;
        end
    end

`ifdef MEM_STREAM_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of ISSUE cycles lost to FIFO backpressure, cleared per command
    always_ff @(posedge clk) begin
        if (!rst_n || accept)                                         stall_q <= '0;
        else if (state_q == ISSUE && !read_en_o && stall_q != '1)     stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: table-driven and randomized bursts checked against a word-queue/occupancy model
module tb_mem_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  base_addr_i = '0;
    logic [15:0] count_i = '0;
    logic        busy_o, done_o, read_en_o, out_last_o, out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [3:0]  read_addr_o;
    logic [15:0] qout_i, out_data_o;
    logic [15:0] mem [16];
`ifdef MEM_STREAM_PERF_EN
    logic [31:0] stall_cycles_o;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign qout_i = mem[read_addr_o];

    mem_stream_reader #(.WIDTH(16), .HEIGHT(16), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .base_addr_i(base_addr_i),
        .count_i    (count_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .read_addr_o(read_addr_o),
        .read_en_o  (read_en_o),
        .qout_i     (qout_i),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i)
`ifdef MEM_STREAM_PERF_EN
        ,
        .stall_cycles_o(stall_cycles_o)
`endif
    );

    typedef struct {
        int base;
        int cnt;
        int pct;
        int hold;
        int spur;
        int exp_words;
        int exp_end;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One command: accept cycle, then per-cycle comparison against the model until done
    task automatic run_burst(input int base, input int cnt, input int pct, input int hold,
                             input int spur, input int exp_words, input int exp_end);
        logic [16:0] q[$];
        int issued = 0, occ = 0, got = 0, stall = 0, cyc = 0, holdrd = 0, lim;
        bit active = 1'b1, done_next = 1'b0, fin = 1'b0, exp_pop, exp_re;
        for (int i = 0; i < cnt; i++) q.push_back({mem[(base + i) % 16], i == cnt - 1});
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = 4'(base); count_i = 16'(cnt); out_ready_i = 1'b0;
        @(negedge clk);
        chk("accept_busy", busy_o, 0);
        while (!fin && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            out_ready_i = (cyc <= hold) ? 1'b0 : ($urandom_range(99) < pct);
            start_i = spur != 0 && active && $urandom_range(3) == 0;
            base_addr_i = 4'($urandom);
            count_i = 16'($urandom_range(1, 9));
            @(negedge clk);
            exp_pop = occ > 0 && out_ready_i;
            exp_re = active && issued < cnt && (occ < 4 || exp_pop);
            chk("read_en", read_en_o, exp_re);
            if (read_en_o) chk("read_addr", read_addr_o, (base + issued) % 16);
            chk("out_valid", out_valid_o, occ > 0);
            if (!out_valid_o) chk("last_empty", out_last_o, 0);
            if (exp_pop && q.size() > 0) begin
                chk("out_data", out_data_o, q[0][16:1]);
                chk("out_last", out_last_o, q[0][0]);
                void'(q.pop_front());
                got++;
            end
            chk("busy", busy_o, active);
            chk("done", done_o, done_next);
            if (done_next) fin = 1'b1;
            if (active && issued < cnt && !exp_re) stall++;
            if (cyc <= hold && exp_re) holdrd++;
            done_next = active && issued == cnt && occ == 0;
            if (done_next) active = 1'b0;
            issued += int'(exp_re);
            occ += int'(exp_re) - int'(exp_pop);
        end
        start_i = 1'b0;
        if (!fin) begin
            n_chk++; n_fail++;
            $display("FAIL burst_timeout: base %0d count %0d got no done within 2000 cycles", base, cnt);
        end
        chk("word_count", got, exp_words);
        chk("end_addr", read_addr_o, exp_end);
        if (hold > 0) begin
            lim = cnt < 4 ? cnt : 4;
            lim = hold < lim ? hold : lim;
            chk("hold_reads", holdrd, lim);
        end
`ifdef MEM_STREAM_PERF_EN
        chk("stall_cycles", stall_cycles_o, stall);
`endif
    endtask

    initial begin
        vec_t vt[8];
        int rd, b, c;
        foreach (mem[i]) mem[i] = 16'($urandom);
        vt[0] = '{3, 5, 100, 0, 0, 5, 8};
        vt[1] = '{6, 0, 100, 0, 0, 0, 6};
        vt[2] = '{0, 10, 100, 12, 0, 10, 10};
        vt[3] = '{14, 4, 100, 0, 0, 4, 2};
        vt[4] = '{5, 6, 60, 0, 1, 6, 11};
        vt[5] = '{15, 20, 50, 0, 0, 20, 3};
        vt[6] = '{9, 3, 25, 3, 1, 3, 12};
        vt[7] = '{1, 1, 100, 0, 0, 1, 2};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_read_en", read_en_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_read_addr", read_addr_o, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++)
            run_burst(vt[i].base, vt[i].cnt, vt[i].pct, vt[i].hold, vt[i].spur, vt[i].exp_words, vt[i].exp_end);
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = 4'd2; count_i = 16'd8; out_ready_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        rd = 0;
        repeat (20) begin
            @(negedge clk);
            if (read_en_o) rd++;
            if (rd == 2) break;
        end
        chk("pre_reset_reads", rd, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_read_en", read_en_o, 0);
        chk("abort_out_valid", out_valid_o, 0);
        chk("abort_busy", busy_o, 0);
        repeat (3) begin
            chk("abort_no_done", done_o, 0);
            @(negedge clk);
        end
        run_burst(2, 8, 70, 0, 1, 8, 10);
        for (int i = 0; i < 20; i++) begin
            b = $urandom_range(15);
            c = $urandom_range(24);
            run_burst(b, c, $urandom_range(20, 100), $urandom_range(6), $urandom_range(1), c, (b + c) % 16);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
